dm_fifo_responder: RTL and testbench

// - Memory-mapped FIFO peripheral that answers the CPU data-memory port with the same SRAM-style protocol as the

---
 rtl/dm_fifo_responder.sv | 175 +++++++++++++++++
 tb/tb_dm_fifo_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_fifo_responder.sv
// ---------------------------------------------------------------------------
// dm_fifo_responder
//   Memory-mapped FIFO peripheral on the CPU data-memory port. It speaks the
//   same SRAM-style protocol as the data SRAM (CS/OE/WEB/A/DI/DO, one-cycle
//   registered read data). The CPU pushes words into a TX FIFO that drains
//   through a valid/ready stream, and a second stream fills an RX FIFO that
//   the CPU pops.
//
//   Register map (A[1:0]):
//     0 TXDATA  W   full-word write pushes DI; a partial-lane write sets err
//     1 RXDATA  R   pops the RX head; popping an empty FIFO returns 0, sets err
//     2 STATUS  R   [31:24] tx_count, [23:16] rx_count, [2] err,
//                   [1] rx_empty, [0] tx_full
//     3 CTRL    R/W [7:4] thresh; [0] tx_flush, [1] rx_flush, [2] err_clr
//                   (bits [2:0] are strobes and read back as 0)
//
//   Ports:
//     clk, rst             rising-edge clock, synchronous active-high reset
//     CS, OE, WEB, A, DI   SRAM-style request (WEB active-low byte lanes)
//     DO                   registered read data
//     out_valid/out_data/out_ready   TX stream (show-ahead head)
//     in_valid/in_data/in_ready      RX stream
//     irq                  only when DM_FIFO_IRQ_EN is defined
//
//   Build option: define DM_FIFO_IRQ_EN to add the registered irq output,
//   irq = err | (thresh != 0 & rx_count >= thresh).
// ---------------------------------------------------------------------------
module dm_fifo_responder #(
   parameter int DEPTH = 8,
   parameter int DW    = 32,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          CS,
   input  logic          OE,
   input  logic [3:0]    WEB,
   input  logic [AW-1:0] A,
   input  logic [DW-1:0] DI,
   output logic [DW-1:0] DO,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready
`ifdef DM_FIFO_IRQ_EN
   ,
   output logic          irq
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] tx_mem [DEPTH];
   logic [DW-1:0] rx_mem [DEPTH];
   logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
   logic [CW-1:0] tx_count, rx_count;
   logic          err;
   logic [3:0]    thresh;

   logic [1:0] sel;
   logic       wr_acc, rd_acc;
   logic       tx_full, rx_empty;
   logic       tx_push_req, tx_push, tx_pop, tx_part;
   logic       rx_pop_req, rx_pop, rx_push;
   logic       ctrl_wr, tx_flush, rx_flush, err_clr, err_set;
   logic       unused_addr;

   function automatic logic [31:0] status_word(input logic [CW-1:0] txc,
                                               input logic [CW-1:0] rxc,
                                               input logic e,
                                               input logic rxe,
                                               input logic txf);
      status_word = {8'(txc), 8'(rxc), 13'b0, e, rxe, txf};
   endfunction

   assign sel         = A[1:0];
   assign unused_addr = &{1'b0, A};

   // A write wins over a read when OE is also high.
   assign wr_acc = CS & (WEB != 4'hF);
   assign rd_acc = CS & OE & (WEB == 4'hF);

   assign tx_full  = (tx_count == CW'(DEPTH));
   assign rx_empty = (rx_count == '0);

   assign out_valid = (tx_count != '0);
   assign out_data  = tx_mem[tx_rd];
   assign in_ready  = (rx_count != CW'(DEPTH));

   // Fullness is judged on the registered count, so a push into a full TX
   // FIFO is dropped even if the stream drains an entry on the same edge.
   assign tx_push_req = wr_acc & (sel == 2'd0) & (WEB == 4'h0);
   assign tx_part     = wr_acc & (sel == 2'd0) & (WEB != 4'h0);
   assign tx_push     = tx_push_req & ~tx_full;
   assign tx_pop      = out_valid & out_ready;

   assign rx_pop_req = rd_acc & (sel == 2'd1);
   assign rx_pop     = rx_pop_req & ~rx_empty;
   assign rx_push    = in_valid & in_ready;

   // CTRL lives entirely in byte lane 0.
   assign ctrl_wr  = wr_acc & (sel == 2'd3) & ~WEB[0];
   assign tx_flush = ctrl_wr & DI[0];
   assign rx_flush = ctrl_wr & DI[1];
   assign err_clr  = ctrl_wr & DI[2];
   assign err_set  = (tx_push_req & tx_full) | tx_part | (rx_pop_req & rx_empty);

   // FIFO storage: data only, no reset.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= DI;
      if (rx_push) rx_mem[rx_wr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_count <= '0;
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_count <= '0;
         err      <= 1'b0;
         thresh   <= 4'h0;
         DO       <= '0;
      end else begin
         // A flush discards the same-cycle push/pop of that FIFO.
         if (tx_flush) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
         end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
         end

         if (rx_flush) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
         end else begin
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
         end

         // A new error beats a same-cycle clear.
         if (err_set)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;

         if (ctrl_wr) thresh <= DI[7:4];

         if (rd_acc) begin
            case (sel)
               2'd0:    DO <= '0;
               2'd1:    DO <= rx_empty ? '0 : rx_mem[rx_rd];
               2'd2:    DO <= DW'(status_word(tx_count, rx_count, err, rx_empty, tx_full));
               default: DO <= DW'({24'b0, thresh, 4'b0});
            endcase
         end
      end
   end

`ifdef DM_FIFO_IRQ_EN
   // Evaluated from registered state, so irq trails its cause by one cycle.
   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= err | ((thresh != 4'h0) && (8'(rx_count) >= 8'(thresh)));
   end
`endif

endmodule

// File: tb/tb_dm_fifo_responder.sv
// ---------------------------------------------------------------------------
// tb_dm_fifo_responder
//   Directed bench for dm_fifo_responder (DEPTH=8, DW=32, AW=14). A queue
//   based reference model tracks both FIFOs, err, thresh and the expected
//   read data; a compare process checks the DUT against it on every falling
//   edge, and hand-computed literals pin key points of each scenario.
//   Define DM_FIFO_IRQ_EN on both files to exercise the irq output.
// ---------------------------------------------------------------------------
module tb_dm_fifo_responder;

   localparam int DEPTH = 8;
   localparam int DW    = 32;
   localparam int AW    = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          CS = 1'b0, OE = 1'b0;
   logic [3:0]    WEB = 4'hF;
   logic [AW-1:0] A = '0;
   logic [DW-1:0] DI = '0;
   logic [DW-1:0] DO;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
`ifdef DM_FIFO_IRQ_EN
   logic          irq;
`endif

   int nvec = 0;
   int nerr = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   dm_fifo_responder #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
`ifdef DM_FIFO_IRQ_EN
      , .irq(irq)
`endif
   );

   // ---------------- reference model ----------------
   logic [31:0] txq[$];
   logic [31:0] rxq[$];
   bit          m_err = 1'b0;
   logic [3:0]  m_thr = 4'h0;
   logic [31:0] m_do = '0;
   bit          m_irq = 1'b0;

   always @(posedge clk) begin
      int  tx_n, rx_n;
      bit  n_irq, new_err, clr, fl_tx, fl_rx, push_tx, pop_rx, pop_tx, push_rx;
      if (rst) begin
         txq.delete(); rxq.delete();
         m_err = 0; m_thr = 0; m_do = 0; m_irq = 0;
      end else begin
         tx_n = txq.size();
         rx_n = rxq.size();
         n_irq = m_err || (m_thr != 0 && rx_n >= int'(m_thr));
         new_err = 0; clr = 0; fl_tx = 0; fl_rx = 0; push_tx = 0; pop_rx = 0;
         pop_tx  = (tx_n != 0) && out_ready;
         push_rx = (rx_n != DEPTH) && in_valid;
         if (CS && WEB != 4'hF) begin
            if (A[1:0] == 2'd0) begin
               if (WEB != 4'h0) new_err = 1;
               else if (tx_n == DEPTH) new_err = 1;
               else push_tx = 1;
            end else if (A[1:0] == 2'd3 && !WEB[0]) begin
               m_thr = DI[7:4];
               fl_tx = DI[0]; fl_rx = DI[1]; clr = DI[2];
            end
         end else if (CS && OE) begin
            case (A[1:0])
               2'd0: m_do = 0;
               2'd1: if (rx_n == 0) begin m_do = 0; new_err = 1; end
                     else begin m_do = rxq[0]; pop_rx = 1; end
               2'd2: m_do = {8'(tx_n), 8'(rx_n), 13'b0, m_err, rx_n == 0, tx_n == DEPTH};
               default: m_do = {24'b0, m_thr, 4'b0};
            endcase
         end
         if (fl_tx) txq.delete();
         else begin
            if (pop_tx)  void'(txq.pop_front());
            if (push_tx) txq.push_back(DI);
         end
         if (fl_rx) rxq.delete();
         else begin
            if (pop_rx)  void'(rxq.pop_front());
            if (push_rx) rxq.push_back(in_data);
         end
         if (new_err) m_err = 1;
         else if (clr) m_err = 0;
         m_irq = n_irq;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         chk("model DO", DO, m_do);
         chk("model out_valid", 32'(out_valid), 32'(txq.size() != 0));
         chk("model in_ready", 32'(in_ready), 32'(rxq.size() != DEPTH));
         if (txq.size() != 0) chk("model out_data", out_data, txq[0]);
`ifdef DM_FIFO_IRQ_EN
         chk("model irq", 32'(irq), 32'(m_irq));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] web);
      CS = 1; OE = 0; WEB = web; A = AW'(a); DI = d;
      tick();
      CS = 0; WEB = 4'hF;
   endtask

   task automatic cpu_read(input logic [1:0] a);
      CS = 1; OE = 1; WEB = 4'hF; A = AW'(a);
      tick();
      CS = 0; OE = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst = 1;
      tick(); tick();
      started = 1;
      rst = 0;
      chk("reset DO", DO, 32'h0);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);

      // status after reset
      cpu_read(2'd2);
      chk("reset status", DO, 32'h0000_0002);

      // single TX word
      cpu_write(2'd0, 32'hDEAD_BEEF, 4'h0);
      chk("tx one valid", 32'(out_valid), 32'h1);
      chk("tx one data", out_data, 32'hDEAD_BEEF);
      out_ready = 1; tick(); out_ready = 0;
      chk("tx one drained", 32'(out_valid), 32'h0);

      // overflow: ninth push dropped
      for (int i = 1; i <= 9; i++) cpu_write(2'd0, 32'(i), 4'h0);
      cpu_read(2'd2);
      chk("tx overflow status", DO, 32'h0800_0007);
      cpu_write(2'd3, 32'h4, 4'h0);
      cpu_read(2'd2);
      chk("err cleared status", DO, 32'h0800_0003);
      for (int i = 1; i <= 8; i++) begin
         chk("tx drain order", out_data, 32'(i));
         out_ready = 1; tick();
      end
      out_ready = 0;
      chk("tx drained empty", 32'(out_valid), 32'h0);

      // RX stream of three, then underflow
      in_valid = 1;
      in_data = 32'hAAAA_0001; tick();
      in_data = 32'hBBBB_0002; tick();
      in_data = 32'hCCCC_0003; tick();
      in_valid = 0;
      cpu_read(2'd1); chk("rx pop A", DO, 32'hAAAA_0001);
      cpu_read(2'd1); chk("rx pop B", DO, 32'hBBBB_0002);
      cpu_read(2'd1); chk("rx pop C", DO, 32'hCCCC_0003);
      cpu_read(2'd1); chk("rx underflow DO", DO, 32'h0);
      cpu_read(2'd2); chk("rx underflow status", DO, 32'h0000_0006);
      cpu_write(2'd3, 32'h4, 4'h0);

      // RX full: push blocked during same-cycle pop
      in_valid = 1;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h10 + 32'(i); tick();
      end
      chk("rx full in_ready", 32'(in_ready), 32'h0);
      in_data = 32'h99;
      cpu_read(2'd1);
      chk("rx full pop head", DO, 32'h10);
      in_valid = 0;
      cpu_read(2'd2);
      chk("rx count 7", DO, 32'h0007_0000);
      in_valid = 1; tick(); in_valid = 0;
      cpu_read(2'd2);
      chk("rx count 8", DO, 32'h0008_0000);
      for (int i = 1; i < 8; i++) begin
         cpu_read(2'd1);
         chk("rx drain order", DO, 32'h10 + 32'(i));
      end
      cpu_read(2'd1);
      chk("rx drain last", DO, 32'h99);

      // partial-lane TX write: error, no push
      cpu_write(2'd0, 32'h1234_5678, 4'h1);
      cpu_read(2'd2);
      chk("partial write status", DO, 32'h0000_0006);
      cpu_read(2'd0);
      chk("txdata read zero", DO, 32'h0);

      // flush overrides same-cycle stream pop
      for (int i = 0; i < 3; i++) cpu_write(2'd0, 32'h40 + 32'(i), 4'h0);
      out_ready = 1;
      cpu_write(2'd3, 32'h5, 4'h0);
      out_ready = 0;
      cpu_read(2'd2);
      chk("flush status", DO, 32'h0000_0002);
      cpu_write(2'd3, 32'h57, 4'h0);
      cpu_read(2'd3);
      chk("ctrl readback", DO, 32'h0000_0050);
      cpu_write(2'd3, 32'h00, 4'hE);

`ifdef DM_FIFO_IRQ_EN
      cpu_write(2'd3, 32'h30, 4'h0);
      in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h70 + 32'(i); tick();
      end
      in_valid = 0;
      chk("irq not yet", 32'(irq), 32'h0);
      tick();
      chk("irq threshold", 32'(irq), 32'h1);
      cpu_read(2'd1);
      chk("irq pop data", DO, 32'h70);
      tick();
      chk("irq released", 32'(irq), 32'h0);
`endif

      // reset mid-operation
      for (int i = 0; i < 2; i++) cpu_write(2'd0, 32'h80 + 32'(i), 4'h0);
      in_valid = 1; in_data = 32'h55;
      CS = 1; OE = 1; A = AW'(2);
      rst = 1; tick();
      rst = 0; CS = 0; OE = 0; in_valid = 0;
      chk("midrst DO", DO, 32'h0);
      chk("midrst out_valid", 32'(out_valid), 32'h0);
      cpu_read(2'd2);
      chk("midrst status", DO, 32'h0000_0002);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
